clock_ctrl: RTL

- Synthesizable run/halt/single-step controller for the simulated CPU clock.
- Derives a programmable-period, programmable-duty, phase-delayed `cpu_clk` from the free-running system clock using cycle counters, with no `#` delays.
- Sits between the testbench/debug front end and the CPU core.
- Starts and stops the CPU clock on request, honours the CPU's halt request, and counts issued CPU cycles.

---
 rtl/clock_ctrl_pkg.sv | 29 ++
 rtl/clock_ctrl_down_counter.sv | 27 ++
 rtl/clock_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and helpers for the CPU clock controller.
package clock_ctrl_pkg;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_TICK_W = 32;

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StHigh,
    StLow,
    StHalted
  } clk_state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
  } cfg_t;

  // Forces a legal waveform: at least one cycle high and one cycle low.
  function automatic cfg_t sanitize_cfg(input logic [31:0] period, input logic [31:0] high);
    cfg_t c;
    c.period = (period < 32'd2) ? 32'd2 : period;
    c.high   = (high == 32'd0) ? 32'd1 : high;
    if (c.high >= c.period) c.high = c.period - 32'd1;
    return c;
  endfunction

endpackage

// File: rtl/clock_ctrl_down_counter.sv
// Loadable down counter; zero flag marks the last cycle of a timed interval.
module down_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/clock_ctrl.sv
// Run/halt/single-step controller producing a programmable CPU clock from clk.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DEF_PERIOD = 4,
  parameter int unsigned DEF_HIGH   = 2,
  parameter int unsigned TICK_W     = DEF_TICK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_step,
  input  logic              i_halt_req,
  input  logic              i_cfg_load,
  input  logic [CNT_W-1:0]  i_cfg_period,
  input  logic [CNT_W-1:0]  i_cfg_high,
  input  logic [CNT_W-1:0]  i_cfg_phase,
  output logic              o_cpu_clk,
  output logic              o_cpu_tick,
  output logic              o_cfg_err,
  output logic              o_halted,
  output logic              o_busy,
  output logic [TICK_W-1:0] o_tick_count
);

  clk_state_t        r_state;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high;
  logic [CNT_W-1:0]  r_phase;
  logic              r_halt_pend;
  logic              r_step_mode;
  logic              r_ret_halt;
  logic              r_cpu_clk;
  logic              r_cpu_tick;
  logic              r_cfg_err;
  logic              r_halted;
  logic              r_busy;
  logic [TICK_W-1:0] r_tick_count;

  clk_state_t       w_state_d;
  logic             w_step_mode_d;
  logic             w_ret_halt_d;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;
  logic             w_halt_hit;
  logic             w_cfg_state;
  logic             w_active;
  cfg_t             w_cfg;

  assign w_halt_hit  = r_halt_pend | i_halt_req;
  assign w_cfg_state = (r_state == StIdle) || (r_state == StHalted);
  assign w_active    = (r_state == StDelay) || (r_state == StHigh) || (r_state == StLow);
  assign w_cfg       = sanitize_cfg(32'(i_cfg_period), 32'(i_cfg_high));

  down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Counters hold (interval length - 1) so the zero flag marks the last cycle.
  always_comb begin
    w_state_d     = r_state;
    w_step_mode_d = r_step_mode;
    w_ret_halt_d  = r_ret_halt;
    w_cnt_load    = 1'b0;
    w_cnt_dec     = 1'b0;
    w_cnt_val     = '0;
    unique case (r_state)
      StIdle: begin
        if (i_run || i_step) begin
          w_step_mode_d = !i_run;
          w_ret_halt_d  = 1'b0;
          w_cnt_load    = 1'b1;
          if (r_phase == '0) begin
            w_state_d = StHigh;
            w_cnt_val = r_high - 1'b1;
          end else begin
            w_state_d = StDelay;
            w_cnt_val = r_phase - 1'b1;
          end
        end
      end
      StDelay: begin
        if (w_cnt_zero) begin
          w_state_d  = StHigh;
          w_cnt_load = 1'b1;
          w_cnt_val  = r_high - 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      StHigh: begin
        if (w_cnt_zero) begin
          w_state_d  = StLow;
          w_cnt_load = 1'b1;
          w_cnt_val  = r_period - r_high - 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      StLow: begin
        if (w_cnt_zero) begin
          if (w_halt_hit) begin
            w_state_d     = StHalted;
            w_step_mode_d = 1'b0;
          end else if (r_step_mode) begin
            w_state_d     = r_ret_halt ? StHalted : StIdle;
            w_step_mode_d = 1'b0;
          end else if (!i_run) begin
            w_state_d = StIdle;
          end else begin
            w_state_d  = StHigh;
            w_cnt_load = 1'b1;
            w_cnt_val  = r_high - 1'b1;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      StHalted: begin
        if (i_step) begin
          w_state_d     = StHigh;
          w_step_mode_d = 1'b1;
          w_ret_halt_d  = 1'b1;
          w_cnt_load    = 1'b1;
          w_cnt_val     = r_high - 1'b1;
        end else if (!i_run) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_period     <= CNT_W'(DEF_PERIOD);
      r_high       <= CNT_W'(DEF_HIGH);
      r_phase      <= '0;
      r_halt_pend  <= 1'b0;
      r_step_mode  <= 1'b0;
      r_ret_halt   <= 1'b0;
      r_cpu_clk    <= 1'b0;
      r_cpu_tick   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_halted     <= 1'b0;
      r_busy       <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_step_mode <= w_step_mode_d;
      r_ret_halt  <= w_ret_halt_d;
      r_cpu_clk   <= (w_state_d == StHigh);
      r_halted    <= (w_state_d == StHalted);
      r_busy      <= (w_state_d == StDelay) || (w_state_d == StHigh) || (w_state_d == StLow);
      r_cfg_err   <= i_cfg_load && !w_cfg_state;
      if ((w_state_d == StHigh) && (r_state != StHigh)) begin
        r_cpu_tick   <= 1'b1;
        r_tick_count <= r_tick_count + 1'b1;
      end else begin
        r_cpu_tick <= 1'b0;
      end
      if (w_state_d == StHalted) begin
        r_halt_pend <= 1'b0;
      end else if (w_active && i_halt_req) begin
        r_halt_pend <= 1'b1;
      end
      if (i_cfg_load && w_cfg_state) begin
        r_period <= CNT_W'(w_cfg.period);
        r_high   <= CNT_W'(w_cfg.high);
        r_phase  <= i_cfg_phase;
      end
    end
  end

  assign o_cpu_clk    = r_cpu_clk;
  assign o_cpu_tick   = r_cpu_tick;
  assign o_cfg_err    = r_cfg_err;
  assign o_halted     = r_halted;
  assign o_busy       = r_busy;
  assign o_tick_count = r_tick_count;

endmodule
